axis_data_join: RTL and testbench

- Joins NUM_IN independent AXI-Stream data inputs into one lock-stepped output beat, each output beat carrying one item set from every input.
- Generalises the main/aux input pairing of the LMS shell to N inputs with per-input buffering, packet-boundary checking and automatic resynchronisation.
- Sits between the shell's chdr_to_axis_data outputs and user DSP logic, in the axis_data_clk domain.

---
 rtl/axis_data_join.sv | 172 +++++++++++++++++
 tb/tb_axis_data_join.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_data_join.sv
// Joins NUM_IN AXI-Stream inputs into one lock-stepped output beat, with per-input
// FIFOs, tlast mismatch detection and resynchronisation by discarding to packet end.
module axis_data_join #(
  parameter int unsigned NUM_IN      = 2,
  parameter int unsigned ITEM_W      = 32,
  parameter int unsigned NIPC        = 1,
  parameter int unsigned FIFO_LOG2   = 5,
  parameter int unsigned STRICT_LAST = 1
) (
  input  logic                          axis_data_clk,
  input  logic                          axis_data_rst_n,
  input  logic [NUM_IN*NIPC*ITEM_W-1:0] s_axis_tdata,
  input  logic [NUM_IN*NIPC-1:0]        s_axis_tkeep,
  input  logic [NUM_IN-1:0]             s_axis_tlast,
  input  logic [NUM_IN-1:0]             s_axis_tvalid,
  output logic [NUM_IN-1:0]             s_axis_tready,
  input  logic [63:0]                   s_axis_ttimestamp,
  input  logic                          s_axis_thas_time,
  input  logic [15:0]                   s_axis_tlength,
  input  logic                          s_axis_teob,
  output logic [NUM_IN*NIPC*ITEM_W-1:0] m_axis_tdata,
  output logic [NIPC-1:0]               m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [63:0]                   m_axis_ttimestamp,
  output logic                          m_axis_thas_time,
  output logic [15:0]                   m_axis_tlength,
  output logic                          m_axis_teob,
  output logic [15:0]                   stat_mismatch_cnt,
  output logic                          stat_resync,
  input  logic                          stat_clear
);
  localparam int unsigned DW    = NIPC * ITEM_W;
  localparam int unsigned EW    = DW + NIPC + 1;
  localparam int unsigned SW    = 64 + 1 + 16 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PW    = FIFO_LOG2 + 1;

  typedef enum logic {PASS, RESYNC} state_t;

  state_t                   state;
  logic                     up;
  logic [NUM_IN-1:0]        empty, full, push, pop, head_last;
  logic [NUM_IN-1:0]        pending, pend_next;
  logic [EW-1:0]            head [NUM_IN];
  logic [SW-1:0]            sb_head;
  logic                     out_free, do_join, mismatch;
  logic [NUM_IN*DW-1:0]     join_data;
  logic [NIPC-1:0]          join_keep;
  logic [15:0]              mismatch_cnt;

  // Per-input FIFO of {data, keep, last}; input 0 also stores the sideband.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_fifo
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign empty[k]         = (wr_ptr == rd_ptr);
    assign full[k]          = (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]) &&
                              (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]);
    assign s_axis_tready[k] = up && !full[k];
    assign push[k]          = s_axis_tvalid[k] && s_axis_tready[k];
    assign head[k]          = mem[rd_ptr[FIFO_LOG2-1:0]];
    assign head_last[k]     = head[k][0];

    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
      if (!axis_data_rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[k])  rd_ptr <= rd_ptr + PW'(1);
      end
    end

    always_ff @(posedge axis_data_clk) begin
      if (push[k])
        mem[wr_ptr[FIFO_LOG2-1:0]] <= {s_axis_tdata[k*DW +: DW], s_axis_tkeep[k*NIPC +: NIPC],
                                       s_axis_tlast[k]};
    end

    if (k == 0) begin : g_sb
      logic [SW-1:0] sb_mem [DEPTH];
      assign sb_head = sb_mem[rd_ptr[FIFO_LOG2-1:0]];
      always_ff @(posedge axis_data_clk) begin
        if (push[k])
          sb_mem[wr_ptr[FIFO_LOG2-1:0]] <= {s_axis_ttimestamp, s_axis_thas_time,
                                            s_axis_tlength, s_axis_teob};
      end
    end
  end

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign do_join  = (state == PASS) && !(|empty) && out_free;
  assign mismatch = (STRICT_LAST != 0) && do_join && (|head_last) && !(&head_last);

  // Gather joined payload; keep is the AND across inputs.
  always_comb begin
    join_data = '0;
    join_keep = '1;
    for (int k = 0; k < NUM_IN; k++) begin
      join_data[k*DW +: DW] = head[k][EW-1 -: DW];
      join_keep             = join_keep & head[k][NIPC:1];
    end
  end

  // Pop all heads on a join; in RESYNC drain only the pending inputs up to their tlast.
  always_comb begin
    pop       = '0;
    pend_next = pending;
    if (do_join) begin
      pop = '1;
    end else if (state == RESYNC) begin
      pop       = pending & ~empty;
      pend_next = pending & ~(pop & head_last);
    end
  end

  always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
    if (!axis_data_rst_n) begin
      state             <= PASS;
      up                <= 1'b0;
      pending           <= '0;
      mismatch_cnt      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_ttimestamp <= '0;
      m_axis_thas_time  <= 1'b0;
      m_axis_tlength    <= '0;
      m_axis_teob       <= 1'b0;
    end else begin
      up <= 1'b1;
      if (do_join) begin
        m_axis_tvalid     <= 1'b1;
        m_axis_tdata      <= join_data;
        m_axis_tkeep      <= join_keep;
        m_axis_tlast      <= mismatch || head_last[0];
        m_axis_ttimestamp <= sb_head[SW-1 -: 64];
        m_axis_thas_time  <= sb_head[17];
        m_axis_tlength    <= sb_head[16:1];
        m_axis_teob       <= sb_head[0];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        PASS: begin
          if (mismatch) begin
            pending <= ~head_last;
            state   <= RESYNC;
          end
        end
        RESYNC: begin
          pending <= pend_next;
          if (pend_next == '0) state <= PASS;
        end
        default: state <= PASS;
      endcase

      if (stat_clear)
        mismatch_cnt <= '0;
      else if (mismatch && mismatch_cnt != 16'hFFFF)
        mismatch_cnt <= mismatch_cnt + 16'd1;
    end
  end

  assign stat_mismatch_cnt = mismatch_cnt;
  assign stat_resync       = (state == RESYNC);

endmodule

// File: tb/tb_axis_data_join.sv
// Directed bench for axis_data_join: a STRICT_LAST=1 and a STRICT_LAST=0 instance share
// the same input stimulus; each task checks its own scenario against hand-computed values.
module tb_axis_data_join;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [1:0]  s_tkeep = '0, s_tlast = '0, s_tvalid = '0, s_tready, s_tready_l;
  logic [63:0] s_ts = '0;
  logic        s_has_time = 1'b0, s_eob = 1'b0;
  logic [15:0] s_len = '0;
  logic        m_ready = 1'b1, stat_clear = 1'b0;

  logic [63:0] m_data, m_ts, m_data_l, m_ts_l;
  logic        m_keep, m_last, m_valid, m_ht, m_eob, resync;
  logic        m_keep_l, m_last_l, m_valid_l, m_ht_l, m_eob_l, resync_l;
  logic [15:0] m_len, cnt, m_len_l, cnt_l;

  always #5 clk = ~clk;

  axis_data_join #(.NUM_IN(2), .ITEM_W(32), .NIPC(1), .FIFO_LOG2(5), .STRICT_LAST(1)) dut (
    .axis_data_clk(clk), .axis_data_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_ttimestamp(s_ts), .s_axis_thas_time(s_has_time), .s_axis_tlength(s_len),
    .s_axis_teob(s_eob),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_ttimestamp(m_ts), .m_axis_thas_time(m_ht), .m_axis_tlength(m_len),
    .m_axis_teob(m_eob),
    .stat_mismatch_cnt(cnt), .stat_resync(resync), .stat_clear(stat_clear));

  axis_data_join #(.NUM_IN(2), .ITEM_W(32), .NIPC(1), .FIFO_LOG2(5), .STRICT_LAST(0)) dut_l (
    .axis_data_clk(clk), .axis_data_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_l),
    .s_axis_ttimestamp(s_ts), .s_axis_thas_time(s_has_time), .s_axis_tlength(s_len),
    .s_axis_teob(s_eob),
    .m_axis_tdata(m_data_l), .m_axis_tkeep(m_keep_l), .m_axis_tlast(m_last_l),
    .m_axis_tvalid(m_valid_l), .m_axis_tready(m_ready),
    .m_axis_ttimestamp(m_ts_l), .m_axis_thas_time(m_ht_l), .m_axis_tlength(m_len_l),
    .m_axis_teob(m_eob_l),
    .stat_mismatch_cnt(cnt_l), .stat_resync(resync_l), .stat_clear(stat_clear));

  typedef struct packed {logic keep; logic last; logic [31:0] data;} ibeat_t;
  typedef struct packed {logic keep; logic last; logic [63:0] data; logic [63:0] ts;
                         logic [15:0] len;} obeat_t;

  ibeat_t q0[$], q1[$];
  obeat_t oq[$], oq_l[$];
  int     d0, d1, hold, first_valid, acc_hold0, acc_hold1;
  bit     held_changed, t0_drop, resync_seen;
  int     total = 0, bad = 0;

  task automatic add(input int k, input logic [31:0] base, input int n, input int nokeep);
    for (int i = 0; i < n; i++) begin
      ibeat_t b;
      b.data = base + 32'(i);
      b.last = (i == n - 1);
      b.keep = (i != nokeep);
      if (k == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic apply_reset();
    s_tvalid = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    q0.delete(); q1.delete();
  endtask

  // Cycle loop: drive both inputs from q0/q1 and capture output beats of both instances.
  task automatic run(input int n);
    int i0 = 0, i1 = 0;
    obeat_t prev = '0, cur, cur_l;
    bit prev_held = 0;
    oq.delete(); oq_l.delete();
    first_valid = -1; acc_hold0 = 0; acc_hold1 = 0;
    held_changed = 0; t0_drop = 0; resync_seen = 0;
    for (int c = 0; c < n; c++) begin
      bit a0, a1;
      s_tvalid[0] = (c >= d0) && (i0 < q0.size());
      s_tvalid[1] = (c >= d1) && (i1 < q1.size());
      if (i0 < q0.size()) begin
        s_tdata[31:0] = q0[i0].data; s_tkeep[0] = q0[i0].keep; s_tlast[0] = q0[i0].last;
      end
      if (i1 < q1.size()) begin
        s_tdata[63:32] = q1[i1].data; s_tkeep[1] = q1[i1].keep; s_tlast[1] = q1[i1].last;
      end
      s_ts = 64'd1000 + 64'(i0); s_len = 16'(i0); s_has_time = 1'b1; s_eob = s_tlast[0];
      m_ready = (c >= hold);
      a0 = s_tvalid[0] && s_tready[0];
      a1 = s_tvalid[1] && s_tready[1];
      if (c < hold) begin acc_hold0 += int'(a0); acc_hold1 += int'(a1); end
      if (!s_tready[0]) t0_drop = 1;
      if (resync) resync_seen = 1;
      if (m_valid && first_valid < 0) first_valid = c;
      cur   = '{m_keep, m_last, m_data, m_ts, m_len};
      cur_l = '{m_keep_l, m_last_l, m_data_l, m_ts_l, m_len_l};
      if (prev_held && m_valid && cur != prev) held_changed = 1;
      prev_held = m_valid && !m_ready;
      prev = cur;
      if (m_valid && m_ready) oq.push_back(cur);
      if (m_valid_l && m_ready) oq_l.push_back(cur_l);
      @(posedge clk); #1;
      if (a0) i0++;
      if (a1) i1++;
    end
    s_tvalid = '0;
  endtask

  task automatic test_reset();
    s_tvalid = '0; m_ready = 1'b1; stat_clear = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (s_tready !== 2'b00) begin bad++; $display("FAIL reset_tready got=%b exp=00", s_tready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 64'd0 || m_ts !== 64'd0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", m_data, m_ts); end
    total++; if (cnt !== 16'd0 || resync !== 1'b0) begin bad++; $display("FAIL reset_stat got=%h/%b exp=0/0", cnt, resync); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (s_tready !== 2'b11) begin bad++; $display("FAIL release_tready got=%b exp=11", s_tready); end
  endtask

  task automatic test_aligned();
    apply_reset();
    add(0, 32'h10, 4, -1); add(1, 32'h20, 4, 2);
    d0 = 0; d1 = 0; hold = 0;
    run(14);
    total++; if (oq.size() != 4) begin bad++; $display("FAIL aligned_count got=%0d exp=4", oq.size()); end
    total++; if (first_valid != 2) begin bad++; $display("FAIL aligned_latency got=%0d exp=2", first_valid); end
    for (int i = 0; i < 4; i++) begin
      obeat_t o = (i < oq.size()) ? oq[i] : '0;
      total++;
      if (o.data !== {32'h20 + 32'(i), 32'h10 + 32'(i)} || o.last !== (i == 3) ||
          o.keep !== (i != 2) || o.ts !== 64'd1000 + 64'(i) || o.len !== 16'(i)) begin
        bad++;
        $display("FAIL aligned_beat%0d got=%h last=%b keep=%b ts=%0d exp=%h last=%b keep=%b ts=%0d",
                 i, o.data, o.last, o.keep, o.ts, {32'h20 + 32'(i), 32'h10 + 32'(i)}, i == 3, i != 2, 1000 + i);
      end
    end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL aligned_cnt got=%h exp=0", cnt); end
  endtask

  task automatic test_skew();
    apply_reset();
    add(0, 32'h10, 4, -1); add(1, 32'h20, 4, -1);
    d0 = 0; d1 = 10; hold = 0;
    run(24);
    total++; if (first_valid != 12) begin bad++; $display("FAIL skew_first got=%0d exp=12", first_valid); end
    total++; if (oq.size() != 4) begin bad++; $display("FAIL skew_count got=%0d exp=4", oq.size()); end
    for (int i = 0; i < 4; i++) begin
      obeat_t o = (i < oq.size()) ? oq[i] : '0;
      total++;
      if (o.data !== {32'h20 + 32'(i), 32'h10 + 32'(i)} || o.last !== (i == 3)) begin
        bad++; $display("FAIL skew_beat%0d got=%h last=%b exp=%h last=%b", i, o.data, o.last,
                        {32'h20 + 32'(i), 32'h10 + 32'(i)}, i == 3);
      end
    end
    total++; if (t0_drop) begin bad++; $display("FAIL skew_tready0 got=dropped exp=held"); end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    apply_reset();
    add(0, 32'h100, 40, -1); add(1, 32'h200, 40, -1);
    d0 = 0; d1 = 0; hold = 40;
    run(100);
    total++; if (acc_hold0 != 33 || acc_hold1 != 33) begin bad++; $display("FAIL bp_accepted got=%0d/%0d exp=33/33", acc_hold0, acc_hold1); end
    total++; if (held_changed) begin bad++; $display("FAIL bp_stable got=changed exp=stable"); end
    total++; if (oq.size() != 40) begin bad++; $display("FAIL bp_count got=%0d exp=40", oq.size()); end
    for (int i = 0; i < 40 && i < oq.size(); i++)
      if (oq[i].data !== {32'h200 + 32'(i), 32'h100 + 32'(i)} || oq[i].last !== (i == 39)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_order got=%0d bad beats exp=0", errs); end
  endtask

  task automatic mismatch_stim();
    add(0, 32'h30, 2, -1); add(0, 32'h40, 3, -1);
    add(1, 32'h50, 4, -1); add(1, 32'h60, 3, -1);
    d0 = 0; d1 = 0; hold = 0;
    run(30);
  endtask

  task automatic test_mismatch();
    logic [63:0] exp_d [5] = '{64'h50_0000_0030, 64'h51_0000_0031, 64'h60_0000_0040,
                               64'h61_0000_0041, 64'h62_0000_0042};
    logic        exp_l [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    mismatch_stim();
    total++; if (oq.size() != 5) begin bad++; $display("FAIL strict_count got=%0d exp=5", oq.size()); end
    for (int i = 0; i < 5; i++) begin
      obeat_t o = (i < oq.size()) ? oq[i] : '0;
      total++;
      if (o.data !== exp_d[i] || o.last !== exp_l[i]) begin
        bad++; $display("FAIL strict_beat%0d got=%h last=%b exp=%h last=%b", i, o.data, o.last, exp_d[i], exp_l[i]);
      end
    end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL strict_cnt got=%h exp=1", cnt); end
    total++; if (!resync_seen || resync !== 1'b0) begin bad++; $display("FAIL strict_resync got=seen%0d/now%b exp=seen1/now0", resync_seen, resync); end
  endtask

  task automatic test_loose();
    logic [63:0] exp_d [5] = '{64'h50_0000_0030, 64'h51_0000_0031, 64'h52_0000_0040,
                               64'h53_0000_0041, 64'h60_0000_0042};
    logic        exp_l [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    mismatch_stim();
    total++; if (oq_l.size() != 5) begin bad++; $display("FAIL loose_count got=%0d exp=5", oq_l.size()); end
    for (int i = 0; i < 5; i++) begin
      obeat_t o = (i < oq_l.size()) ? oq_l[i] : '0;
      total++;
      if (o.data !== exp_d[i] || o.last !== exp_l[i]) begin
        bad++; $display("FAIL loose_beat%0d got=%h last=%b exp=%h last=%b", i, o.data, o.last, exp_d[i], exp_l[i]);
      end
    end
    total++; if (cnt_l !== 16'd0 || resync_l !== 1'b0) begin bad++; $display("FAIL loose_cnt got=%h/%b exp=0/0", cnt_l, resync_l); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    add(0, 32'h90, 8, -1); add(1, 32'hA0, 8, -1);
    d0 = 0; d1 = 0; hold = 100;
    run(6);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_prevalid got=%b exp=1", m_valid); end
    rst_n = 1'b0; #1;
    total++; if (m_valid !== 1'b0 || m_data !== 64'd0) begin bad++; $display("FAIL mid_async got=%b/%h exp=0/0", m_valid, m_data); end
    apply_reset();
    add(0, 32'h70, 3, -1); add(1, 32'h80, 3, -1);
    hold = 0;
    run(10);
    total++; if (oq.size() != 3) begin bad++; $display("FAIL mid_count got=%0d exp=3", oq.size()); end
    for (int i = 0; i < 3; i++) begin
      obeat_t o = (i < oq.size()) ? oq[i] : '0;
      total++;
      if (o.data !== {32'h80 + 32'(i), 32'h70 + 32'(i)}) begin
        bad++; $display("FAIL mid_beat%0d got=%h exp=%h", i, o.data, {32'h80 + 32'(i), 32'h70 + 32'(i)});
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    @(negedge clk) force dut.mismatch_cnt = 16'hFFFF;
    @(negedge clk) release dut.mismatch_cnt;
    @(posedge clk); #1;
    mismatch_stim();
    total++; if (!resync_seen) begin bad++; $display("FAIL sat_resync got=0 exp=1"); end
    total++; if (cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h exp=ffff", cnt); end
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL sat_clear got=%h exp=0", cnt); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skew();
    test_backpressure();
    test_mismatch();
    test_loose();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
